// File: rtl/guia05_pkg.sv
// Shared types and constants for the truth-table checker: FSM encoding,
// minterm width, settle-counter width and reference gate truth tables.
package guia05_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned MINTERM_W = 2;
    localparam int unsigned SETTLE_W  = 4;

    localparam logic [MINTERM_W-1:0] LAST_MINTERM = '1;

    // Truth-table columns, bit m = gate output for minterm m = {a,b}.
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expire flags the last cycle of a settle interval
// (count == 1), so a load of N gives N cycles before expiry is acted on.
module settle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == ONE);

endmodule

// File: rtl/tt_checker.sv
// Sweeps minterms 00..11 onto an external 2-input gate, samples its output
// after SETTLE cycles and compares the captured column against exp_tt.
module tt_checker
    import guia05_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] cap_tt,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    state_e               state_q, state_d;
    logic [MINTERM_W-1:0] m_q, m_d;
    logic [3:0]           exp_q, exp_d;
    logic [3:0]           cap_q, cap_d;
    logic [3:0]           err_q, err_d;
    logic [2:0]           ecnt_q, ecnt_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timer_load;
    logic                 timer_expire;

    settle_timer #(.W(SETTLE_W)) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .value  (SETTLE_LD),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        exp_d      = exp_q;
        cap_d      = cap_q;
        err_d      = err_q;
        ecnt_d     = ecnt_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_WAIT;
                    exp_d      = exp_tt;
                    cap_d      = '0;
                    err_d      = '0;
                    ecnt_d     = '0;
                    m_d        = '0;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (timer_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cap_d[m_q] = s;
                if (s != exp_q[m_q]) begin
                    err_d[m_q] = 1'b1;
                    ecnt_d     = ecnt_q + 3'd1;
                end
                if (m_q == LAST_MINTERM) begin
                    state_d = ST_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'b0000);
                end else begin
                    // a/b only move here, on entry to the next minterm's WAIT.
                    state_d    = ST_WAIT;
                    m_d        = m_q + MINTERM_W'(1);
                    a_d        = m_d[1];
                    b_d        = m_d[0];
                    timer_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            err_q   <= '0;
            ecnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign cap_tt    = cap_q;
    assign err_mask  = err_q;
    assign err_count = ecnt_q;

endmodule

// File: tb/tb_tt_checker.sv
// Two checkers (SETTLE=1 and SETTLE=3) run side by side on a behavioural gate
// whose truth table the bench chooses; results come from a truth-table model.
module tb_tt_checker;
    import guia05_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] exp_tt = 4'b0000;
    logic [3:0] gate_tt = 4'b0000;

    logic       s1, a1, b1, busy1, done1, pass1;
    logic [3:0] cap1, err1;
    logic [2:0] cnt1;
    logic       s3, a3, b3, busy3, done3, pass3;
    logic [3:0] cap3, err3;
    logic [2:0] cnt3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign s1 = gate_tt[{a1, b1}];
    assign s3 = gate_tt[{a3, b3}];

    tt_checker #(.SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .exp_tt(exp_tt), .s(s1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .cap_tt(cap1), .err_mask(err1), .err_count(cnt1)
    );

    tt_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .exp_tt(exp_tt), .s(s3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .cap_tt(cap3), .err_mask(err3), .err_count(cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected DONE snapshot {busy,done,pass,cap,err,count,a,b}.
    function automatic logic [16:0] expect_done(input logic [3:0] gtt, input logic [3:0] ett);
        logic [3:0] e;
        e = gtt ^ ett;
        return {1'b0, 1'b1, (e == 4'b0000), gtt, e, 3'($countones(e)), 1'b0, 1'b0};
    endfunction

    task automatic sweep(input string nm, input logic [3:0] gtt, input logic [3:0] ett,
                         input int poke_k, input logic [3:0] poke_exp);
        int d1, d3, sel;
        logic [16:0] want, got1, got3;
        gate_tt = gtt;
        exp_tt  = ett;
        start   = 1'b1;
        step();
        start = 1'b0;
        d1 = -1;
        d3 = -1;
        for (int k = 0; k < 40 && (d1 < 0 || d3 < 0); k++) begin
            if (k == 0) begin
                n_checks++;
                if ({busy1, done1, busy3, done3} !== 4'b1010)
                    $display("FAIL %s start_ack: busy1/done1/busy3/done3=%b want 1010", nm, {busy1, done1, busy3, done3});
                else n_pass++;
            end
            if (k < 8) begin
                sel = k / 2;
                n_checks++;
                if ({a1, b1} !== 2'(sel))
                    $display("FAIL %s ab_s1[k=%0d]: got %b want %b", nm, k, {a1, b1}, 2'(sel));
                else n_pass++;
            end
            if (k < 16) begin
                sel = k / 4;
                n_checks++;
                if ({busy3, a3, b3} !== {1'b1, 2'(sel)})
                    $display("FAIL %s ab_s3[k=%0d]: busy,a,b got %b want %b", nm, k, {busy3, a3, b3}, {1'b1, 2'(sel)});
                else n_pass++;
            end
            if (d1 < 0 && done1 === 1'b1) d1 = k;
            if (d3 < 0 && done3 === 1'b1) d3 = k;
            if (k == poke_k) begin
                start  = 1'b1;
                exp_tt = poke_exp;
            end else begin
                start = 1'b0;
            end
            if (d1 < 0 || d3 < 0) step();
        end
        start = 1'b0;
        n_checks++;
        if (d1 != 8) $display("FAIL %s done_latency_s1: got %0d edges want 8", nm, d1);
        else n_pass++;
        n_checks++;
        if (d3 != 16) $display("FAIL %s done_latency_s3: got %0d edges want 16", nm, d3);
        else n_pass++;
        want = expect_done(gtt, ett);
        got1 = {busy1, done1, pass1, cap1, err1, cnt1, a1, b1};
        got3 = {busy3, done3, pass3, cap3, err3, cnt3, a3, b3};
        n_checks++;
        if (got1 !== want) $display("FAIL %s result_s1: got %b want %b", nm, got1, want);
        else n_pass++;
        n_checks++;
        if (got3 !== want) $display("FAIL %s result_s3: got %b want %b", nm, got3, want);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string nm);
        logic [16:0] got1, got3;
        got1 = {busy1, done1, pass1, cap1, err1, cnt1, a1, b1};
        got3 = {busy3, done3, pass3, cap3, err3, cnt3, a3, b3};
        n_checks++;
        if (got1 !== 17'b0) $display("FAIL %s s1: got %b want all zero", nm, got1);
        else n_pass++;
        n_checks++;
        if (got3 !== 17'b0) $display("FAIL %s s3: got %b want all zero", nm, got3);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check_all_zero("reset_state");
        reset = 1'b0;
        step();
        check_all_zero("idle_hold");
    endtask

    task automatic test_xnor_pass();
        sweep("xnor_pass", TT_XNOR, TT_XNOR, -1, 4'b0000);
    endtask

    task automatic test_xor_fail();
        sweep("xor_vs_xnor", TT_XOR, TT_XNOR, -1, 4'b0000);
    endtask

    task automatic test_const_one();
        sweep("s_const1", 4'b1111, TT_XNOR, -1, 4'b0000);
    endtask

    task automatic test_restart_ignored();
        sweep("busy_restart", TT_XNOR, TT_XNOR, 3, 4'b0000);
    endtask

    task automatic test_back_to_back();
        sweep("b2b_and", TT_AND, TT_AND, -1, 4'b0000);
        sweep("b2b_or", TT_OR, TT_AND, -1, 4'b0000);
    endtask

    task automatic test_reset_mid_sweep();
        gate_tt = TT_XNOR;
        exp_tt  = TT_XNOR;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        // SETTLE=1 checker now sits in SAMPLE of minterm 2; start collides with reset.
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_all_zero("reset_abort");
        step();
        check_all_zero("post_abort_idle");
        sweep("after_abort", TT_XNOR, TT_XNOR, -1, 4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] g, e;
        for (int i = 0; i < 6; i++) begin
            g = 4'($urandom_range(0, 15));
            e = 4'($urandom_range(0, 15));
            sweep($sformatf("rand%0d", i), g, e, (i % 2 == 0) ? 2 + i : -1, ~e);
        end
    endtask

    initial begin
        test_reset();
        test_xnor_pass();
        test_xor_fail();
        test_const_one();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 Parameter SETTLE, default 1, meaning: clock cycles a minterm is held on a/b before s is sampled (legal 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  one-cycle request to run a full truth-table sweep.
REQ-005 exp_tt  input  4  expected output column, where bit m = expected s for minterm m; latched on accepted start.
REQ-006 s  input  1  output of the external 2-input gate under test.
REQ-007 a  output  1  gate input a, driven with minterm bit 1.
REQ-008 b  output  1  gate input b, driven with minterm bit 0.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-011 pass  output  1  valid while done; high iff err_mask == 0.
REQ-012 cap_tt  output  4  captured s value per minterm (bit m).
REQ-013 err_mask  output  4  bit m set iff cap_tt[m] != latched exp_tt[m].
REQ-014 err_count  output  3  population count of err_mask (0..4).

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, SAMPLE and DONE.
REQ-016 IDLE/DONE with start=1: latch exp_tt, clear cap_tt/err_mask/err_count, set minterm m=0, load settle counter with SETTLE, enter WAIT; busy=1, done=0 from that edge.
REQ-017 WAIT: a,b SHALL equal m[1],m[0]; counter decrements each cycle; at count 1 go to SAMPLE.
REQ-018 SAMPLE: capture s into cap_tt[m], set err_mask[m] on mismatch, increment err_count on mismatch; if m==3 go to DONE, else m=m+1, reload counter, go to WAIT.
REQ-019 Each minterm SHALL occupy exactly SETTLE+1 cycles; done SHALL rise exactly 4*(SETTLE+1) rising edges after the edge accepting start.
REQ-020 a,b SHALL change only on WAIT entry and hold stable through SAMPLE of the same minterm.
REQ-021 start while busy SHALL be ignored (no restart, no exp_tt relatch).
REQ-022 start in DONE SHALL restart immediately per REQ-016; done falls on the same edge.
REQ-023 In IDLE and DONE, a=b=0; cap_tt, err_mask, err_count, pass hold last sweep values in DONE.
REQ-024 Minterm counter SHALL be 2 bits and never wrap mid-sweep; exit after m==3.
REQ-025 exp_tt changes after start acceptance SHALL have no effect on the running sweep.

Reset
REQ-026 reset=1 SHALL force IDLE, a=0, b=0, busy=0, done=0, pass=0, cap_tt=0, err_mask=0, err_count=0 on the next rising edge.
REQ-027 reset SHALL abort a sweep in any state; reset overrides a simultaneous start.
REQ-028 All outputs SHALL be registered; no combinational path from s or start to any output.

Structure
REQ-029 Shared package guia05_pkg SHALL hold the state encoding, minterm width (2), and constants TT_XNOR=4'b1001, TT_XOR=4'b0110, TT_AND=4'b1000, TT_OR=4'b1110.
REQ-030 The settle countdown SHALL be a separate sub-module settle_timer (load, value, expire).
REQ-031 The gate under test is external; the checker instantiates no gate.

Verification
REQ-032 XNOR gate on a/b→s, exp_tt=TT_XNOR, SETTLE=1, start pulse → done after 8 edges, cap_tt=1001, err_mask=0000, err_count=0, pass=1.
REQ-033 XOR gate in place, exp_tt=TT_XNOR → cap_tt=0110, err_mask=1111, err_count=4, pass=0.
REQ-034 XNOR gate, SETTLE=3, a/b monitored → a,b sequence 00,01,10,11 each held 4 cycles; done after 16 edges.
REQ-035 start re-pulsed at cycle 3 of a sweep with exp_tt changed to 0000 → ignored; result as REQ-032.
REQ-036 reset asserted during SAMPLE of minterm 2 → next edge all outputs zero, IDLE; new start yields full correct sweep.
REQ-037 s forced to 1 constantly, exp_tt=TT_XNOR → cap_tt=1111, err_mask=0110, err_count=2, pass=0.
